// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps the shared 8-bit datapath through
// fetch/decode/exec/mem/writeback and runs a timed req/ack data-memory handshake.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic [15:0] instr,
  input  logic        flag_z,
  input  logic        mem_ack,
  output logic [15:0] ir,
  output logic        ir_en,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        reg_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        err,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // wait_cnt counts MEM cycles without ack; the last allowed cycle has this count
  localparam logic [3:0] LAST_WAIT = 4'(MEM_TIMEOUT - 1);

  state_t     cur;
  logic       single;
  logic [3:0] wait_cnt;

  logic   is_alu, is_load, is_store, is_beq, is_halt;
  logic   retire_now;
  state_t after_retire;

  assign is_alu   = (ir[15:13] <= 3'b100);
  assign is_load  = (ir[15:13] == 3'b101);
  assign is_store = (ir[15:13] == 3'b110);
  assign is_beq   = (ir[15:12] == 4'b1110);
  assign is_halt  = (ir[15:12] == 4'b1111);

  assign retire_now = ((cur == S_EXEC) && is_beq) ||
                      ((cur == S_MEM) && is_store && mem_ack) ||
                      (cur == S_WB);

  // A single-stepped instruction always falls back to IDLE, even if run rose meanwhile
  assign after_retire = (run && !single) ? S_FETCH : S_IDLE;

  assign state = cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= S_IDLE;
      ir       <= 16'h0000;
      retired  <= 16'h0000;
      err      <= 1'b0;
      halted   <= 1'b0;
      single   <= 1'b0;
      wait_cnt <= 4'd0;
    end else begin
      if (retire_now) begin
        retired <= retired + 16'd1;
        if (after_retire == S_IDLE) single <= 1'b0;
      end
      case (cur)
        S_IDLE: begin
          if (run) begin
            cur <= S_FETCH;
          end else if (step) begin
            cur    <= S_FETCH;
            single <= 1'b1;
          end
        end
        S_FETCH: begin
          ir  <= instr;
          cur <= S_DECODE;
        end
        S_DECODE: begin
          if (is_halt) begin
            cur    <= S_HALT;
            halted <= 1'b1;
          end else begin
            cur <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_beq) begin
            cur <= after_retire;
          end else if (is_load || is_store) begin
            cur      <= S_MEM;
            wait_cnt <= 4'd0;
          end else begin
            cur <= S_WB;
          end
        end
        // An ack arriving on the final allowed cycle beats the timeout
        S_MEM: begin
          if (mem_ack) begin
            cur <= is_store ? after_retire : S_WB;
          end else if (wait_cnt == LAST_WAIT) begin
            cur    <= S_HALT;
            halted <= 1'b1;
            err    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_WB: begin
          cur <= after_retire;
        end
        S_HALT: begin
          cur <= S_HALT;
        end
        default: begin
          cur    <= S_HALT;
          halted <= 1'b1;
          err    <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    ir_en   = 1'b0;
    pc_en   = 1'b0;
    pc_sel  = 1'b0;
    reg_we  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (cur)
      S_FETCH: ir_en = 1'b1;
      S_EXEC: begin
        if (is_beq) begin
          pc_en  = 1'b1;
          pc_sel = flag_z;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        pc_en   = is_store && mem_ack;
      end
      S_WB: begin
        reg_we = is_alu || is_load;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: randomized instruction streams
// compared against an instruction-level timeline model.
module tb_multicycle_sequencer;

  localparam int TIMEOUT   = 15;
  localparam int ST_IDLE   = 0;
  localparam int ST_FETCH  = 1;
  localparam int ST_DECODE = 2;
  localparam int ST_EXEC   = 3;
  localparam int ST_MEM    = 4;
  localparam int ST_WB     = 5;
  localparam int ST_HALT   = 6;

  logic        clk = 1'b0;
  logic        reset, run, step, flag_z, mem_ack;
  logic [15:0] instr;
  logic [15:0] ir, retired;
  logic        ir_en, pc_en, pc_sel, reg_we, mem_req, mem_we, halted, err;
  logic [2:0]  state;

  multicycle_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .instr(instr),
    .flag_z(flag_z), .mem_ack(mem_ack), .ir(ir), .ir_en(ir_en), .pc_en(pc_en),
    .pc_sel(pc_sel), .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we),
    .state(state), .halted(halted), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // program to issue: instruction, flag_z seen in EXEC, MEM cycles before ack
  logic [15:0] p_ins[$];
  bit          p_fz[$];
  int          p_w[$];

  // expected timeline: states per cycle, pc_en as (cycle*2+pc_sel), reg_we cycles
  int exp_seq[$];
  int exp_pcen[$];
  int exp_regwe[$];
  int exp_memreq, exp_memwe, exp_iren, exp_ret;
  bit exp_halt, exp_err;

  int obs_seq[$];
  int obs_pcen[$];
  int obs_regwe[$];
  int obs_memreq, obs_memwe, obs_iren;
  int end_state;

  task automatic p_clear();
    p_ins.delete(); p_fz.delete(); p_w.delete();
  endtask

  task automatic p_add(input logic [15:0] ins, input bit fz, input int w);
    p_ins.push_back(ins); p_fz.push_back(fz); p_w.push_back(w);
  endtask

  task automatic model_instr(input logic [15:0] ins, input bit fz, input int w, output bit stop);
    int base;
    int m;
    logic [2:0] cls;
    base = exp_seq.size();
    cls  = ins[15:13];
    stop = 1'b0;
    exp_iren++;
    exp_seq.push_back(ST_FETCH);
    exp_seq.push_back(ST_DECODE);
    if (cls == 3'b111 && ins[12]) begin
      exp_halt = 1'b1;
      stop     = 1'b1;
    end else begin
      exp_seq.push_back(ST_EXEC);
      if (cls == 3'b111) begin
        exp_pcen.push_back((base + 2) * 2 + int'(fz));
        exp_ret++;
      end else if (cls <= 3'b100) begin
        exp_seq.push_back(ST_WB);
        exp_pcen.push_back((base + 3) * 2);
        exp_regwe.push_back(base + 3);
        exp_ret++;
      end else begin
        m = (w < TIMEOUT) ? w + 1 : TIMEOUT;
        for (int i = 0; i < m; i++) exp_seq.push_back(ST_MEM);
        exp_memreq += m;
        if (cls == 3'b110) exp_memwe += m;
        if (w >= TIMEOUT) begin
          exp_halt = 1'b1;
          exp_err  = 1'b1;
          stop     = 1'b1;
        end else if (cls == 3'b110) begin
          exp_pcen.push_back((exp_seq.size() - 1) * 2);
          exp_ret++;
        end else begin
          exp_seq.push_back(ST_WB);
          exp_pcen.push_back((exp_seq.size() - 1) * 2);
          exp_regwe.push_back(exp_seq.size() - 1);
          exp_ret++;
        end
      end
    end
  endtask

  function automatic int seq_diff();
    int n = (obs_seq.size() < exp_seq.size()) ? obs_seq.size() : exp_seq.size();
    for (int i = 0; i < n; i++) if (obs_seq[i] != exp_seq[i]) return i;
    return (obs_seq.size() == exp_seq.size()) ? -1 : n;
  endfunction

  function automatic int pcen_diff();
    int n = (obs_pcen.size() < exp_pcen.size()) ? obs_pcen.size() : exp_pcen.size();
    for (int i = 0; i < n; i++) if (obs_pcen[i] != exp_pcen[i]) return i;
    return (obs_pcen.size() == exp_pcen.size()) ? -1 : n;
  endfunction

  function automatic int regwe_diff();
    int n = (obs_regwe.size() < exp_regwe.size()) ? obs_regwe.size() : exp_regwe.size();
    for (int i = 0; i < n; i++) if (obs_regwe[i] != exp_regwe[i]) return i;
    return (obs_regwe.size() == exp_regwe.size()) ? -1 : n;
  endfunction

  // Drives the queued program from IDLE and records every non-idle cycle
  task automatic run_program(input bit use_step);
    bit stop = 1'b0;
    bit done = 1'b0;
    int idx = -1;
    int ci = 0;
    int memcnt = 0;
    int cyc = 0;
    int st;
    int n = p_ins.size();
    exp_seq.delete(); exp_pcen.delete(); exp_regwe.delete();
    exp_memreq = 0; exp_memwe = 0; exp_iren = 0; exp_ret = 0;
    exp_halt = 1'b0; exp_err = 1'b0;
    for (int i = 0; i < n && !stop; i++) model_instr(p_ins[i], p_fz[i], p_w[i], stop);
    obs_seq.delete(); obs_pcen.delete(); obs_regwe.delete();
    obs_memreq = 0; obs_memwe = 0; obs_iren = 0;
    end_state = -1;
    if (use_step) step = 1'b1; else run = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      st = int'(state);
      if ((st == ST_IDLE && obs_seq.size() > 0) || st == ST_HALT) begin
        end_state = st;
        done = 1'b1;
        break;
      end
      if (st == ST_FETCH) begin
        idx++;
        ci = (idx < n) ? idx : n - 1;
        instr = (idx < n) ? p_ins[idx] : 16'hF000;
        memcnt = 0;
        if (!use_step) run = (idx < n - 1);
      end
      step    = (st != ST_IDLE) && ((st == ST_DECODE) || ($urandom_range(0, 1) == 1));
      flag_z  = (st == ST_EXEC) ? p_fz[ci] : 1'($urandom_range(0, 1));
      if (st == ST_MEM) begin
        mem_ack = (memcnt == p_w[ci]);
        memcnt++;
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      #1;
      if (st != ST_IDLE) begin
        obs_seq.push_back(st);
        if (pc_en === 1'b1) obs_pcen.push_back(cyc * 2 + int'(pc_sel));
        if (reg_we === 1'b1) obs_regwe.push_back(cyc);
        obs_memreq += int'(mem_req);
        obs_memwe  += int'(mem_req & mem_we);
        obs_iren   += int'(ir_en);
        cyc++;
      end
    end
    run = 1'b0; step = 1'b0; mem_ack = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("[TB] FAIL program_completion: still running after 2000 cycles, state %0d, required IDLE or HALT", state);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; step = 1'b1; mem_ack = 1'b1; flag_z = 1'b1;
    instr = 16'($urandom);
    @(posedge clk); #1;
    tests++; if (state !== 3'(ST_IDLE)) begin fails++; $display("[TB] FAIL reset_state: got %0d, expected 0", state); end
    tests++; if (ir !== 16'h0000) begin fails++; $display("[TB] FAIL reset_ir: got %h, expected 0000", ir); end
    tests++; if (retired !== 16'h0000) begin fails++; $display("[TB] FAIL reset_retired: got %0d, expected 0", retired); end
    tests++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b, expected 0", err); end
    tests++; if (halted !== 1'b0) begin fails++; $display("[TB] FAIL reset_halted: got %b, expected 0", halted); end
    tests++;
    if ({ir_en, pc_en, pc_sel, reg_we, mem_req, mem_we} !== 6'b0) begin
      fails++;
      $display("[TB] FAIL reset_strobes: got %b, expected 000000", {ir_en, pc_en, pc_sel, reg_we, mem_req, mem_we});
    end
    @(posedge clk); #1;
    tests++; if (state !== 3'(ST_IDLE)) begin fails++; $display("[TB] FAIL reset_priority: got state %0d with run high, expected 0", state); end
    reset = 1'b0; run = 1'b0; step = 1'b0; mem_ack = 1'b0; flag_z = 1'b0;
  endtask

  task automatic test_alu();
    logic [15:0] r0 = retired;
    p_clear(); p_add(16'h0C12, 1'($urandom_range(0, 1)), 0);
    run_program(1'b0);
    tests++; if (seq_diff() != -1) begin fails++; $display("[TB] FAIL alu_states: diverge at %0d, got %0d states, expected %0d", seq_diff(), obs_seq.size(), exp_seq.size()); end
    tests++; if (pcen_diff() != -1) begin fails++; $display("[TB] FAIL alu_pc_en: got %0d pulses, expected %0d (diverge at %0d)", obs_pcen.size(), exp_pcen.size(), pcen_diff()); end
    tests++; if (regwe_diff() != -1) begin fails++; $display("[TB] FAIL alu_reg_we: got %0d pulses, expected %0d", obs_regwe.size(), exp_regwe.size()); end
    tests++; if (16'(retired - r0) !== 16'd1) begin fails++; $display("[TB] FAIL alu_retired: got +%0d, expected +1", 16'(retired - r0)); end
    tests++; if (ir !== 16'h0C12) begin fails++; $display("[TB] FAIL alu_ir: got %h, expected 0c12", ir); end
    tests++; if (end_state != ST_IDLE) begin fails++; $display("[TB] FAIL alu_end_state: got %0d, expected 0", end_state); end
  endtask

  task automatic test_store_wait();
    logic [15:0] r0 = retired;
    p_clear(); p_add(16'hC000, 1'b0, 2);
    run_program(1'b0);
    tests++; if (seq_diff() != -1) begin fails++; $display("[TB] FAIL store_states: diverge at %0d, got %0d states, expected %0d", seq_diff(), obs_seq.size(), exp_seq.size()); end
    tests++; if (pcen_diff() != -1) begin fails++; $display("[TB] FAIL store_pc_en: got %0d pulses, expected %0d", obs_pcen.size(), exp_pcen.size()); end
    tests++; if (obs_memreq != exp_memreq) begin fails++; $display("[TB] FAIL store_mem_req: got %0d cycles, expected %0d", obs_memreq, exp_memreq); end
    tests++; if (obs_memwe != exp_memwe) begin fails++; $display("[TB] FAIL store_mem_we: got %0d cycles, expected %0d", obs_memwe, exp_memwe); end
    tests++; if (regwe_diff() != -1) begin fails++; $display("[TB] FAIL store_reg_we: got %0d pulses, expected %0d", obs_regwe.size(), exp_regwe.size()); end
    tests++; if (16'(retired - r0) !== 16'(exp_ret)) begin fails++; $display("[TB] FAIL store_retired: got +%0d, expected +%0d", 16'(retired - r0), exp_ret); end
  endtask

  task automatic test_beq();
    logic [15:0] r0;
    for (int k = 0; k < 2; k++) begin
      r0 = retired;
      p_clear(); p_add(16'hE000, (k == 0), 0);
      run_program(1'b0);
      tests++; if (seq_diff() != -1) begin fails++; $display("[TB] FAIL beq_states fz=%0d: got %0d states, expected %0d", k == 0, obs_seq.size(), exp_seq.size()); end
      tests++; if (pcen_diff() != -1) begin fails++; $display("[TB] FAIL beq_pc_sel fz=%0d: got code %0d, expected %0d", k == 0, (obs_pcen.size() > 0) ? obs_pcen[0] : -1, exp_pcen[0]); end
      tests++; if (16'(retired - r0) !== 16'd1) begin fails++; $display("[TB] FAIL beq_retired: got +%0d, expected +1", 16'(retired - r0)); end
    end
  endtask

  task automatic test_step();
    logic [15:0] r0 = retired;
    bit stayed = 1'b1;
    p_clear(); p_add({3'($urandom_range(0, 4)), 13'($urandom)}, 1'b0, 0);
    run_program(1'b1);
    tests++; if (seq_diff() != -1) begin fails++; $display("[TB] FAIL step_states: got %0d states, expected %0d", obs_seq.size(), exp_seq.size()); end
    tests++; if (16'(retired - r0) !== 16'd1) begin fails++; $display("[TB] FAIL step_retired: got +%0d, expected +1", 16'(retired - r0)); end
    tests++; if (end_state != ST_IDLE) begin fails++; $display("[TB] FAIL step_end_state: got %0d, expected 0", end_state); end
    for (int c = 0; c < 6; c++) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (state !== 3'(ST_IDLE)) stayed = 1'b0;
    end
    tests++; if (!stayed) begin fails++; $display("[TB] FAIL step_stays_idle: got state %0d, expected 0", state); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r0;
    logic [15:0] ins;
    int k;
    for (int p = 0; p < 3; p++) begin
      r0 = retired;
      p_clear();
      for (int i = 0; i < 12; i++) begin
        ins = 16'($urandom);
        k = $urandom_range(0, 3);
        case (k)
          0: ins[15:13] = 3'($urandom_range(0, 4));
          1: ins[15:13] = 3'b101;
          2: ins[15:13] = 3'b110;
          default: ins[15:12] = 4'b1110;
        endcase
        p_add(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 4));
      end
      run_program(1'b0);
      tests++; if (seq_diff() != -1) begin fails++; $display("[TB] FAIL b2b_states prog %0d: diverge at %0d, got %0d states, expected %0d", p, seq_diff(), obs_seq.size(), exp_seq.size()); end
      tests++; if (pcen_diff() != -1) begin fails++; $display("[TB] FAIL b2b_pc_en prog %0d: diverge at %0d, got %0d pulses, expected %0d", p, pcen_diff(), obs_pcen.size(), exp_pcen.size()); end
      tests++; if (regwe_diff() != -1) begin fails++; $display("[TB] FAIL b2b_reg_we prog %0d: got %0d pulses, expected %0d", p, obs_regwe.size(), exp_regwe.size()); end
      tests++; if (obs_memreq != exp_memreq || obs_memwe != exp_memwe) begin fails++; $display("[TB] FAIL b2b_mem prog %0d: got req %0d we %0d, expected req %0d we %0d", p, obs_memreq, obs_memwe, exp_memreq, exp_memwe); end
      tests++; if (obs_iren != exp_iren) begin fails++; $display("[TB] FAIL b2b_ir_en prog %0d: got %0d, expected %0d", p, obs_iren, exp_iren); end
      tests++; if (16'(retired - r0) !== 16'(exp_ret)) begin fails++; $display("[TB] FAIL b2b_retired prog %0d: got +%0d, expected +%0d", p, 16'(retired - r0), exp_ret); end
      tests++; if (end_state != ST_IDLE) begin fails++; $display("[TB] FAIL b2b_end_state prog %0d: got %0d, expected 0", p, end_state); end
    end
  endtask

  task automatic test_mem_timeout();
    logic [15:0] r0 = retired;
    p_clear(); p_add(16'hA123, 1'b0, TIMEOUT - 1);
    run_program(1'b0);
    tests++; if (seq_diff() != -1) begin fails++; $display("[TB] FAIL late_ack_states: got %0d states, expected %0d", obs_seq.size(), exp_seq.size()); end
    tests++; if (16'(retired - r0) !== 16'd1 || err !== 1'b0) begin fails++; $display("[TB] FAIL late_ack_accept: got retired +%0d err %b, expected +1 err 0", 16'(retired - r0), err); end
    r0 = retired;
    p_clear(); p_add(16'hA456, 1'b0, 99);
    run_program(1'b0);
    tests++; if (seq_diff() != -1) begin fails++; $display("[TB] FAIL timeout_states: got %0d states, expected %0d", obs_seq.size(), exp_seq.size()); end
    tests++; if (obs_memreq != exp_memreq) begin fails++; $display("[TB] FAIL timeout_mem_req: got %0d cycles, expected %0d", obs_memreq, exp_memreq); end
    tests++; if (state !== 3'(ST_HALT) || halted !== 1'b1) begin fails++; $display("[TB] FAIL timeout_halt: got state %0d halted %b, expected 6 1", state, halted); end
    tests++; if (err !== 1'(exp_err)) begin fails++; $display("[TB] FAIL timeout_err: got %b, expected %b", err, exp_err); end
    tests++; if (16'(retired - r0) !== 16'd0 || pcen_diff() != -1) begin fails++; $display("[TB] FAIL timeout_no_retire: got +%0d and %0d pc_en, expected +0 and 0", 16'(retired - r0), obs_pcen.size()); end
  endtask

  task automatic test_halt_sticky();
    logic [15:0] r0 = retired;
    bit stuck = 1'b1;
    for (int c = 0; c < 8; c++) begin
      run = 1'b1;
      step = 1'($urandom_range(0, 1));
      mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (state !== 3'(ST_HALT) || halted !== 1'b1 || err !== 1'b1) stuck = 1'b0;
    end
    tests++; if (!stuck) begin fails++; $display("[TB] FAIL halt_sticky: got state %0d halted %b err %b, expected 6 1 1", state, halted, err); end
    tests++; if (16'(retired - r0) !== 16'd0) begin fails++; $display("[TB] FAIL halt_retired: got +%0d, expected +0", 16'(retired - r0)); end
    do_reset();
    tests++; if (state !== 3'(ST_IDLE) || halted !== 1'b0) begin fails++; $display("[TB] FAIL halt_reset_state: got %0d halted %b, expected 0 0", state, halted); end
    tests++; if (err !== 1'b0 || retired !== 16'h0000) begin fails++; $display("[TB] FAIL halt_reset_clear: got err %b retired %0d, expected 0 0", err, retired); end
  endtask

  task automatic test_halt_instr();
    logic [15:0] r0 = retired;
    p_clear();
    p_add({4'b1111, 12'($urandom)}, 1'b0, 0);
    p_add(16'h0C12, 1'b0, 0);
    run_program(1'b0);
    tests++; if (seq_diff() != -1) begin fails++; $display("[TB] FAIL halt_instr_states: got %0d states, expected %0d", obs_seq.size(), exp_seq.size()); end
    tests++; if (end_state != ST_HALT || err !== 1'b0) begin fails++; $display("[TB] FAIL halt_instr_end: got state %0d err %b, expected 6 0", end_state, err); end
    tests++; if (16'(retired - r0) !== 16'd0 || obs_pcen.size() != 0) begin fails++; $display("[TB] FAIL halt_instr_retire: got +%0d and %0d pc_en, expected +0 and 0", 16'(retired - r0), obs_pcen.size()); end
    do_reset();
  endtask

  task automatic test_reset_during_mem();
    int mcount = 0;
    bit reached = 1'b0;
    instr = {3'b101, 13'($urandom)};
    mem_ack = 1'b0;
    run = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (state === 3'(ST_FETCH)) run = 1'b0;
      if (state === 3'(ST_MEM)) mcount++;
      if (mcount == 3) begin
        reached = 1'b1;
        break;
      end
    end
    tests++; if (!reached) begin fails++; $display("[TB] FAIL reset_mem_reach: got %0d MEM cycles, expected 3", mcount); end
    reset = 1'b1;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0 || pc_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_strobes: got mem_req %b pc_en %b, expected 0 0", mem_req, pc_en); end
    tests++; if (state !== 3'(ST_IDLE) || retired !== 16'h0000) begin fails++; $display("[TB] FAIL reset_mem_state: got state %0d retired %0d, expected 0 0", state, retired); end
    mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_wait();
    test_beq();
    test_step();
    test_back_to_back();
    test_mem_timeout();
    test_halt_sticky();
    test_halt_instr();
    test_reset_during_mem();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
